// File: rtl/csr_hpm_responder.sv
// Counter/timer CSR responder: mcycle, minstret, hpmcounter3..16 and their read-only
// user shadows. One request at a time; the response is held on a valid/ready channel.
module csr_hpm_responder #(
    parameter int XLEN    = 64,
    parameter int NUM_EVT = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [11:0]        req_addr_i,
    input  logic [1:0]         req_op_i,
    input  logic [XLEN-1:0]    req_wdata_i,
    input  logic [1:0]         priv_lvl_i,
    input  logic [31:0]        mcounteren_i,
    input  logic [1:0]         instret_i,
    input  logic [NUM_EVT-1:0] events_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [XLEN-1:0]    rsp_rdata_o,
    output logic               rsp_err_o
);
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;
    localparam logic [1:0] PRIV_M   = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic [XLEN-1:0]   r_mcycle;
    logic [XLEN-1:0]   r_minstret;
    logic [XLEN-1:0]   r_evt [NUM_EVT];

    logic [4:0]        w_idx;
    logic              w_is_b;
    logic              w_is_c;
    logic              w_err;
    logic              w_accept;
    logic              w_wr_en;
    logic [XLEN-1:0]   w_old;
    logic [XLEN-1:0]   w_wval;

    // 0xB00..0xB1F and 0xC00..0xC1F share the low five address bits as counter index
    assign w_idx    = req_addr_i[4:0];
    assign w_is_b   = (req_addr_i[11:5] == 7'h58);
    assign w_is_c   = (req_addr_i[11:5] == 7'h60);
    assign w_accept = (r_state == ST_IDLE) && req_valid_i;
    assign w_wr_en  = w_accept && !w_err && w_is_b && (req_op_i != OP_READ);

    // Access check: address ownership, privilege, read-only shadows, mcounteren gating
    always_comb begin
        w_err = 1'b0;
        if (!(w_is_b || w_is_c) || (w_idx == 5'd1)) begin
            w_err = 1'b1;
        end else if (w_is_b) begin
            w_err = (priv_lvl_i != PRIV_M);
        end else if (req_op_i != OP_READ) begin
            w_err = 1'b1;
        end else if (priv_lvl_i != PRIV_M) begin
            w_err = !mcounteren_i[w_idx];
        end else begin
            w_err = 1'b0;
        end
    end

    // Current counter value; reserved indices read as zero
    always_comb begin
        w_old = '0;
        if (w_idx == 5'd0) begin
            w_old = r_mcycle;
        end else if (w_idx == 5'd2) begin
            w_old = r_minstret;
        end else begin
            for (int i = 0; i < NUM_EVT; i++) begin
                w_old = (w_idx == 5'(i + 3)) ? r_evt[i] : w_old;
            end
        end
    end

    // Write value per operation
    always_comb begin
        w_wval = '0;
        case (req_op_i)
            OP_WRITE: w_wval = req_wdata_i;
            OP_SET:   w_wval = w_old | req_wdata_i;
            OP_CLR:   w_wval = w_old & ~req_wdata_i;
            default:  w_wval = w_old;
        endcase
    end

    // Counters: a written counter takes the write value instead of incrementing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
            for (int i = 0; i < NUM_EVT; i++) begin
                r_evt[i] <= '0;
            end
        end else begin
            r_mcycle   <= (w_wr_en && (w_idx == 5'd0)) ? w_wval : r_mcycle + XLEN'(1'b1);
            r_minstret <= (w_wr_en && (w_idx == 5'd2)) ? w_wval : r_minstret + XLEN'(instret_i);
            for (int i = 0; i < NUM_EVT; i++) begin
                r_evt[i] <= (w_wr_en && (w_idx == 5'(i + 3))) ? w_wval
                                                               : r_evt[i] + XLEN'(events_i[i]);
            end
        end
    end

    // Request/response FSM with registered response fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_state     <= ST_RESP;
                        r_req_ready <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_err ? '0 : w_old;
                        r_rsp_err   <= w_err;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_csr_hpm_responder.sv
// Self-checking bench for csr_hpm_responder: directed corner sequences, an access table,
// and random traffic against an array-of-counters reference model.
module tb_csr_hpm_responder;
    localparam int XLEN    = 64;
    localparam int NUM_EVT = 14;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [11:0]        req_addr = 12'h000;
    logic [1:0]         req_op = 2'b00;
    logic [XLEN-1:0]    req_wdata = '0;
    logic [1:0]         priv_lvl = 2'b11;
    logic [31:0]        mcounteren = 32'h0;
    logic [1:0]         instret = 2'b00;
    logic [NUM_EVT-1:0] events = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [XLEN-1:0]    rsp_rdata;
    logic               rsp_err;

    csr_hpm_responder #(.XLEN(XLEN), .NUM_EVT(NUM_EVT)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_op_i(req_op), .req_wdata_i(req_wdata),
        .priv_lvl_i(priv_lvl), .mcounteren_i(mcounteren),
        .instret_i(instret), .events_i(events),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: 32 counter slots indexed by address low bits
    logic [63:0] m_cnt [32];
    bit          m_busy;
    logic [63:0] m_rdata;
    bit          m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit m_impl(input int i);
        return (i == 0) || (i == 2) || (i >= 3 && i < 3 + NUM_EVT);
    endfunction

    function automatic logic [63:0] m_incr(input int i);
        if (i == 0) return 64'd1;
        if (i == 2) return 64'(instret);
        if (i >= 3 && i < 3 + NUM_EVT) return 64'(events[i-3]);
        return 64'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 64'd0;
        m_busy  = 1'b0;
        m_rdata = 64'd0;
        m_err   = 1'b0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        bit          wr;
        int          widx;
        logic [63:0] wval;
        wr = 1'b0; widx = -1; wval = 64'd0;
        if (!m_busy && req_valid) begin
            int a, idx;
            bit in_m, in_u, e;
            a    = int'(req_addr);
            idx  = a % 32;
            in_m = (a >= 'hB00) && (a <= 'hB1F);
            in_u = (a >= 'hC00) && (a <= 'hC1F);
            e    = !(in_m || in_u) || (idx == 1);
            if (in_m && priv_lvl != 2'b11) e = 1'b1;
            if (in_u && req_op != 2'b00) e = 1'b1;
            if (in_u && req_op == 2'b00 && priv_lvl != 2'b11 && !mcounteren[idx]) e = 1'b1;
            m_err   = e;
            m_rdata = e ? 64'd0 : m_cnt[idx];
            if (!e && in_m && req_op != 2'b00) begin
                wr   = 1'b1;
                widx = idx;
                if (req_op == 2'b01)      wval = req_wdata;
                else if (req_op == 2'b10) wval = m_cnt[idx] | req_wdata;
                else                      wval = m_cnt[idx] & ~req_wdata;
            end
            m_busy = 1'b1;
        end else if (m_busy && rsp_ready) begin
            m_busy = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            if (m_impl(i)) m_cnt[i] = (wr && i == widx) ? wval : m_cnt[i] + m_incr(i);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("req_ready", 64'(req_ready), 64'(!m_busy));
        check("rsp_valid", 64'(rsp_valid), 64'(m_busy));
        if (m_busy) begin
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("rsp_err", 64'(rsp_err), 64'(m_err));
        end
    endtask

    task automatic issue(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd,
                         input logic [1:0] pv, input logic [31:0] mc);
        req_addr = a; req_op = op; req_wdata = wd; priv_lvl = pv; mcounteren = mc;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic complete();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic do_req(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd,
                          input logic [1:0] pv, input logic [31:0] mc,
                          output logic [63:0] rd, output logic er);
        issue(a, op, wd, pv, mc);
        rd = rsp_rdata;
        er = rsp_err;
        complete();
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [63:0] wd;
        logic [1:0]  priv;
        logic [31:0] mcen;
        logic        exp_err;
    } vec_t;

    initial begin
        vec_t        tbl [18];
        logic [63:0] rd;
        logic        er;
        logic [63:0] held;
        logic [63:0] exp_v;

        tbl[0]  = '{12'hB00, 2'b00, 64'h0,    2'b11, 32'h0,         1'b0};
        tbl[1]  = '{12'hB10, 2'b00, 64'h0,    2'b11, 32'h0,         1'b0};
        tbl[2]  = '{12'hB11, 2'b00, 64'h0,    2'b11, 32'h0,         1'b0};
        tbl[3]  = '{12'hB1F, 2'b01, 64'hDEAD, 2'b11, 32'h0,         1'b0};
        tbl[4]  = '{12'hB1F, 2'b00, 64'h0,    2'b11, 32'h0,         1'b0};
        tbl[5]  = '{12'hB05, 2'b01, 64'h55,   2'b00, 32'hFFFF_FFFF, 1'b1};
        tbl[6]  = '{12'hB05, 2'b00, 64'h0,    2'b01, 32'hFFFF_FFFF, 1'b1};
        tbl[7]  = '{12'hC10, 2'b00, 64'h0,    2'b00, 32'h0001_0000, 1'b0};
        tbl[8]  = '{12'hC10, 2'b00, 64'h0,    2'b00, 32'hFFFE_FFFF, 1'b1};
        tbl[9]  = '{12'hC02, 2'b10, 64'h0,    2'b11, 32'hFFFF_FFFF, 1'b1};
        tbl[10] = '{12'hC00, 2'b00, 64'h0,    2'b01, 32'h0000_0001, 1'b0};
        tbl[11] = '{12'hC1F, 2'b00, 64'h0,    2'b00, 32'h8000_0000, 1'b0};
        tbl[12] = '{12'hC01, 2'b00, 64'h0,    2'b11, 32'hFFFF_FFFF, 1'b1};
        tbl[13] = '{12'hA00, 2'b00, 64'h0,    2'b11, 32'h0,         1'b1};
        tbl[14] = '{12'hD02, 2'b00, 64'h0,    2'b11, 32'h0,         1'b1};
        tbl[15] = '{12'hB20, 2'b00, 64'h0,    2'b11, 32'h0,         1'b1};
        tbl[16] = '{12'hB03, 2'b11, 64'h0,    2'b11, 32'h0,         1'b0};
        tbl[17] = '{12'hC05, 2'b11, 64'h0,    2'b11, 32'hFFFF_FFFF, 1'b1};

        // Reset values
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);
        check("reset_rsp_err", 64'(rsp_err), 64'd0);
        rst = 1'b0;

        // mcycle after 10 idle cycles
        repeat (10) step();
        do_req(12'hB00, 2'b00, 64'd0, 2'b11, 32'h0, rd, er);
        check("mcycle_after_10", rd, 64'd10);
        check("mcycle_err", 64'(er), 64'd0);

        // minstret write suppresses increment, then wraps
        instret = 2'd2;
        issue(12'hB02, 2'b01, ONES, 2'b11, 32'h0);
        instret = 2'd0;
        complete();
        instret = 2'd1;
        issue(12'hB02, 2'b00, 64'd0, 2'b11, 32'h0);
        check("minstret_all_ones", rsp_rdata, ONES);
        instret = 2'd0;
        complete();
        do_req(12'hB02, 2'b00, 64'd0, 2'b11, 32'h0, rd, er);
        check("minstret_wrapped", rd, 64'd0);

        // Event counter 3 and user shadow gating
        events = 14'd1;
        repeat (5) step();
        events = '0;
        do_req(12'hC03, 2'b00, 64'd0, 2'b00, 32'h0000_0008, rd, er);
        check("hpm3_user_read", rd, 64'd5);
        check("hpm3_user_err", 64'(er), 64'd0);
        do_req(12'hC03, 2'b00, 64'd0, 2'b00, 32'h0, rd, er);
        check("hpm3_gated_err", 64'(er), 64'd1);
        check("hpm3_gated_rdata", rd, 64'd0);

        // Privilege and address errors
        do_req(12'hB00, 2'b00, 64'd0, 2'b01, 32'hFFFF_FFFF, rd, er);
        check("smode_b00_err", 64'(er), 64'd1);
        do_req(12'hC00, 2'b01, 64'h1234, 2'b11, 32'hFFFF_FFFF, rd, er);
        check("write_c00_err", 64'(er), 64'd1);
        exp_v = m_cnt[0];
        issue(12'hB00, 2'b00, 64'd0, 2'b11, 32'h0);
        check("mcycle_unaffected", rsp_rdata, exp_v);
        complete();
        do_req(12'hB01, 2'b00, 64'd0, 2'b11, 32'h0, rd, er);
        check("b01_err", 64'(er), 64'd1);
        do_req(12'hC01, 2'b00, 64'd0, 2'b11, 32'hFFFF_FFFF, rd, er);
        check("c01_err", 64'(er), 64'd1);

        // Set / clear on counter 4
        do_req(12'hB04, 2'b01, 64'h0F, 2'b11, 32'h0, rd, er);
        do_req(12'hB04, 2'b10, 64'hF0, 2'b11, 32'h0, rd, er);
        check("set_old", rd, 64'h0F);
        do_req(12'hB04, 2'b11, 64'h0F, 2'b11, 32'h0, rd, er);
        check("clear_old", rd, 64'hFF);
        do_req(12'hB04, 2'b00, 64'd0, 2'b11, 32'h0, rd, er);
        check("clear_new", rd, 64'hF0);

        // Response held under back-pressure, then reset mid-hold
        issue(12'hB04, 2'b00, 64'd0, 2'b11, 32'h0);
        held = rsp_rdata;
        check("hold_first", held, 64'hF0);
        req_addr = 12'hB02; req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("hold_rdata_stable", rsp_rdata, held);
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        #2 rst = 1'b1;
        #1;
        check("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midreset_req_ready", 64'(req_ready), 64'd1);
        check("midreset_mcycle", dut.r_mcycle, 64'd0);
        check("midreset_minstret", dut.r_minstret, 64'd0);
        check("midreset_hpm4", dut.r_evt[1], 64'd0);
        req_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Access table with random background activity
        for (int t = 0; t < 18; t++) begin
            instret = 2'($urandom_range(0, 2));
            events  = NUM_EVT'($urandom);
            do_req(tbl[t].addr, tbl[t].op, tbl[t].wd, tbl[t].priv, tbl[t].mcen, rd, er);
            check($sformatf("table_err_%0d", t), 64'(er), 64'(tbl[t].exp_err));
        end

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       req_addr = 12'hB00 | 12'($urandom_range(0, 31));
                1:       req_addr = 12'hC00 | 12'($urandom_range(0, 31));
                2:       req_addr = 12'($urandom);
                default: req_addr = 12'hB00 | 12'($urandom_range(0, 4));
            endcase
            req_valid  = 1'($urandom);
            req_op     = 2'($urandom);
            req_wdata  = {$urandom, $urandom};
            priv_lvl   = 2'($urandom);
            mcounteren = $urandom;
            rsp_ready  = 1'($urandom);
            instret    = 2'($urandom_range(0, 2));
            events     = NUM_EVT'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_hpm_responder.md
Name: csr_hpm_responder

Overview:
CSR-bus responder for the counter/timer address space: mcycle, minstret, the machine performance counters (0xB03-0xB1F) and their user read-only shadows (0xC00-0xC1F). It sits behind the CSR access initiator in the execute/commit stage. It accepts one read or read-modify-write request at a time, returns the data on a valid/ready response channel, and increments every counter from pipeline event strobes.

Parameters:
XLEN, 64, counter and data width
NUM_EVT, 14, implemented event counters, mapped to indices 3..16 (0xB03-0xB10)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid_i  in  1  CSR request valid
req_ready_o  out  1  responder can accept a request
req_addr_i  in  12  CSR address
req_op_i  in  2  00 read, 01 write, 10 set bits, 11 clear bits
req_wdata_i  in  XLEN  write/set/clear operand
priv_lvl_i  in  2  current privilege: 00 U, 01 S, 11 M
mcounteren_i  in  32  counter-enable mask for S/U shadow reads
instret_i  in  2  instructions retired this cycle (0..2)
events_i  in  NUM_EVT  one-cycle event strobes; bit i drives counter 3+i
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  initiator accepts response
rsp_rdata_o  out  XLEN  old CSR value (read data)
rsp_err_o  out  1  illegal access; initiator raises illegal-instruction

Behaviour:
- Reset values: all counters 0, state IDLE, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0. req_ready_o is 1 in IDLE.
- FSM has two states:
  - IDLE: req_ready_o=1. On req_valid_i, register the response and go to RESP.
  - RESP: req_ready_o=0, rsp_valid_o=1. rsp_rdata_o and rsp_err_o are held stable. On rsp_ready_i, go to IDLE.
- Latency: response valid the cycle after acceptance. Back-to-back throughput is one request per 2 cycles.
- Read data is the counter value at the acceptance edge, before that cycle's increment.
- Address decode:
  - 0xB00 mcycle; 0xB02 minstret; 0xB03..0xB10 event counters; 0xB11..0xB1F reserved. Reserved counters read 0, writes are silently dropped, no error.
  - 0xC00/0xC02..0xC1F are read-only shadows of 0xB00/0xB02..0xB1F.
  - Any other address, including 0xB01 and 0xC01 (time), sets rsp_err_o=1. Other blocks own those addresses.
- Access check; any violation gives rsp_err_o=1, rsp_rdata_o=0 and no state change:
  - Bxx addresses require priv_lvl_i=11.
  - Cxx write ops (01/10/11) are always illegal, whatever the operand.
  - Cxx read with priv≠11 requires mcounteren_i[addr[4:0]]=1.
- Write value by op: 01 wdata; 10 old|wdata; 11 old&~wdata. Ops 10/11 with wdata=0 still write (value unchanged).
- The write commits at the acceptance edge. The targeted counter takes the write value and does not increment that cycle. All other counters increment normally.
- Increments, every cycle, independent of the FSM:
  - mcycle += 1
  - minstret += instret_i
  - counter[3+i] += events_i[i]
  - All additions are modulo 2^XLEN: all-ones + 1 = 0.
- Reset mid-transaction aborts the request: FSM to IDLE, response dropped, counters cleared.
- Requests are not accepted in RESP. The initiator holds req_valid_i, and the request is accepted after the response handshake.

Test Plan:
- Reset, then idle 10 cycles, M-mode read 0xB00 -> rsp_rdata_o=10 one cycle after acceptance; rsp_err_o=0.
- M-mode write 0xB02 with 0xFFFF_FFFF_FFFF_FFFF and instret_i=2 on the same edge -> next cycle minstret=all-ones (increment suppressed). The following cycle, with instret_i=1, it wraps to 0.
- events_i[0] pulsed 5 times, then U-mode read 0xC03:
  - with mcounteren_i[3]=1 -> 5, no error;
  - with mcounteren_i[3]=0 -> err=1, rdata=0.
- S-mode read 0xB00 -> err=1; M-mode write 0xC00 -> err=1 and mcycle unaffected. M-mode read 0xB01 / 0xC01 -> err=1.
- Set op 0xB04 with wdata=0xF0 on a counter holding 0x0F -> rdata=0x0F, new value 0xFF. Then clear op wdata=0x0F -> rdata=0xFF, new value 0xF0.
- Hold rsp_ready_i=0 for 4 cycles with a second request pending -> rsp_rdata_o stable, req_ready_o=0. Assert rst mid-hold -> rsp_valid_o=0 and all counters 0 immediately.
